// File: rtl/freq_meter_pkg.sv
// freq_meter shared definitions.
// Edge-select encodings, FSM states and the saturating increment.
package freq_meter_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    localparam int SAT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] v,
        input logic [SAT_W-1:0] max
    );
        return (v >= max) ? max : v + 1;
    endfunction

endpackage

// File: rtl/edge_counter_ch.sv
// One freq_meter channel: synchronizer, edge qualify,
// saturating window accumulator with sticky overflow.
module edge_counter_ch
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             sig,
    input  logic             clear,
    input  logic             latch,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] win_cnt,
    output logic             win_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1;
    logic             s2;
    logic             hist;
    logic [2:0]       fill;
    logic             armed;
    logic             rise;
    logic             fall;
    logic             edge_det;
    logic             at_max;
    logic [CNT_W-1:0] acc;
    logic             ovf;

    // history is trusted only once it holds a post-reset sample
    assign armed  = fill[2];
    assign rise   = s2 & ~hist;
    assign fall   = ~s2 & hist;
    assign at_max = (acc == CNT_MAX);

    // two-stage synchronizer, history stage and fill tracker
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
            fill <= 3'b000;
        end else begin
            s1   <= sig;
            s2   <= s1;
            hist <= s2;
            fill <= {fill[1:0], 1'b1};
        end
    end

    // qualify detected transitions by the edge-select mode
    always_comb begin
        edge_det = 1'b0;
        if (armed) begin
            case (mode)
                MODE_FALL: edge_det = fall;
                MODE_BOTH: edge_det = rise | fall;
                default:   edge_det = rise;
            endcase
        end
    end

    // window total including this cycle's edge
    always_comb begin
        win_cnt = acc;
        if (edge_det) begin
            win_cnt = CNT_W'(sat_inc(SAT_W'(acc), SAT_W'(CNT_MAX)));
        end
        win_ovf = ovf | (edge_det & at_max);
    end

    // accumulate; restart on window close or while idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear || latch) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= win_cnt;
            ovf <= win_ovf;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Multi-channel gated edge counter / frequency meter.
// Prescaled gate window, back-to-back windows, latched results.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CH     = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 8,
    parameter int PRE_W  = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic [PRE_W-1:0]    PRESCALE,
    input  logic [GATE_W-1:0]   GATE,
    input  logic [1:0]          MODE,
    input  logic [CH-1:0]       SIG_IN,
    output logic [CH*CNT_W-1:0] COUNT,
    output logic [CH-1:0]       OVF,
    output logic                VALID,
    output logic                BUSY
);

    state_t              state;
    logic [PRE_W-1:0]    pre_q;
    logic [GATE_W-1:0]   gate_q;
    logic [1:0]          mode_q;
    logic [PRE_W-1:0]    pcnt;
    logic [GATE_W-1:0]   gcnt;
    logic                tick;
    logic                close;
    logic                clear;
    logic [CH*CNT_W-1:0] win_cnt;
    logic [CH-1:0]       win_ovf;

    assign tick  = (state == RUN) && (pcnt == pre_q);
    assign close = tick && EN && (gcnt == gate_q);
    assign clear = (state != RUN) || !EN;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_counter_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .sig    (SIG_IN[i]),
            .clear  (clear),
            .latch  (close),
            .mode   (mode_q),
            .win_cnt(win_cnt[i*CNT_W +: CNT_W]),
            .win_ovf(win_ovf[i])
        );
    end

    // window control: shadows, prescaler, gate counter, strobes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            pre_q  <= '0;
            gate_q <= '0;
            mode_q <= MODE_RISE;
            pcnt   <= '0;
            gcnt   <= '0;
            VALID  <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    pcnt <= '0;
                    gcnt <= '0;
                    if (EN) begin
                        state  <= RUN;
                        BUSY   <= 1'b1;
                        pre_q  <= PRESCALE;
                        gate_q <= GATE;
                        mode_q <= MODE;
                    end
                end
                RUN: begin
                    if (!EN) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        pcnt  <= '0;
                        gcnt  <= '0;
                    end else if (tick) begin
                        pcnt <= '0;
                        if (gcnt == gate_q) begin
                            gcnt   <= '0;
                            VALID  <= 1'b1;
                            pre_q  <= PRESCALE;
                            gate_q <= GATE;
                            mode_q <= MODE;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // capture all channel totals together at window close
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            COUNT <= '0;
            OVF   <= '0;
        end else if (close) begin
            COUNT <= win_cnt;
            OVF   <= win_ovf;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter.
// Main instance CNT_W=16, second instance CNT_W=4 for saturation.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en2;
    logic [15:0] pre;
    logic [15:0] pre2;
    logic [7:0]  gate;
    logic [7:0]  gate2;
    logic [1:0]  mode;
    logic [1:0]  mode2;
    logic [3:0]  man;
    logic        sq;
    logic        sq_en;
    logic        tgl;
    logic        tgl_en;
    logic [3:0]  sig;
    logic [3:0]  sig2;
    logic [63:0] count;
    logic [3:0]  ovf;
    logic        valid;
    logic        busy;
    logic [15:0] count2;
    logic [3:0]  ovf2;
    logic        valid2;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    int n;
    bit seen;

    always #5 clk = ~clk;

    assign sig  = man | {3'b000, sq};
    assign sig2 = {2'b00, tgl, 1'b0};

    freq_meter #(
        .CH(4), .CNT_W(16), .GATE_W(8), .PRE_W(16)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .EN(en),
        .PRESCALE(pre), .GATE(gate), .MODE(mode),
        .SIG_IN(sig), .COUNT(count), .OVF(ovf),
        .VALID(valid), .BUSY(busy)
    );

    freq_meter #(
        .CH(4), .CNT_W(4), .GATE_W(8), .PRE_W(16)
    ) dut2 (
        .CLK(clk), .RST_N(rst_n), .EN(en2),
        .PRESCALE(pre2), .GATE(gate2), .MODE(mode2),
        .SIG_IN(sig2), .COUNT(count2), .OVF(ovf2),
        .VALID(valid2), .BUSY(busy2)
    );

    // square wave (3 high / 2 low) and period-2 toggle sources
    initial begin : gen_src
        int ph;
        ph  = 0;
        sq  = 1'b0;
        tgl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sq_en) begin
                sq = (ph < 3);
                ph = (ph == 4) ? 0 : ph + 1;
            end else begin
                sq = 1'b0;
                ph = 0;
            end
            tgl = tgl_en ? ~tgl : 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(
        input  bit    second,
        input  int    budget,
        output int    cyc
    );
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= budget && !got; k++) begin
            step();
            cyc = k;
            if (second ? valid2 : valid) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL valid_timeout observed none expected strobe within %0d", budget);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        en2    = 1'b0;
        pre    = 16'd0;
        pre2   = 16'd0;
        gate   = 8'd9;
        gate2  = 8'd39;
        mode   = 2'b00;
        mode2  = 2'b00;
        man    = 4'b0000;
        sq_en  = 1'b0;
        tgl_en = 1'b0;
        seen   = 1'b0;

        // reset state
        step();
        step();
        chk("rst_count", count, 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // square wave, rising mode, 10-cycle window
        rst_n = 1'b1;
        en    = 1'b1;
        sq_en = 1'b1;
        wait_valid(1'b0, 50, n);
        chk("first_window", 64'(n), 64'd11);
        wait_valid(1'b0, 30, n);
        chk("period_a", 64'(n), 64'd10);
        chk("rise_c0_a", 64'(count[15:0]), 64'd2);
        chk("idle_c123", 64'(count[63:16]), 64'd0);
        wait_valid(1'b0, 30, n);
        chk("period_b", 64'(n), 64'd10);
        chk("rise_c0_b", 64'(count[15:0]), 64'd2);
        mode = 2'b10;
        wait_valid(1'b0, 30, n);
        chk("mode_defer", 64'(count[15:0]), 64'd2);
        wait_valid(1'b0, 30, n);
        chk("both_c0", 64'(count[15:0]), 64'd4);
        sq_en = 1'b0;

        // saturation on the CNT_W=4 instance
        en2    = 1'b1;
        tgl_en = 1'b1;
        wait_valid(1'b1, 100, n);
        chk("sat_c1", 64'(count2[7:4]), 64'd15);
        chk("sat_ovf1", 64'(ovf2[1]), 64'd1);
        chk("sat_c0", 64'(count2[3:0]), 64'd0);
        tgl_en = 1'b0;
        wait_valid(1'b1, 100, n);
        chk("sat_ovf_clr", 64'(ovf2[1]), 64'd0);
        wait_valid(1'b1, 100, n);
        chk("quiet_c1", 64'(count2[7:4]), 64'd0);
        chk("quiet_ovf", 64'(ovf2), 64'd0);
        en2 = 1'b0;

        // edges on either side of the close boundary (both mode)
        wait_valid(1'b0, 30, n);
        wait_valid(1'b0, 30, n);
        chk("bnd_pre_c0", 64'(count[15:0]), 64'd0);
        for (int k = 0; k < 7; k++) step();
        man[2] = 1'b1;
        step();
        man[2] = 1'b0;
        step();
        step();
        chk("bnd_valid_a", 64'(valid), 64'd1);
        chk("bnd_close", 64'(count[47:32]), 64'd1);
        wait_valid(1'b0, 30, n);
        chk("bnd_gap", 64'(n), 64'd10);
        chk("bnd_after", 64'(count[47:32]), 64'd1);

        // gate change mid-window
        gate = 8'd4;
        wait_valid(1'b0, 30, n);
        chk("gate_old", 64'(n), 64'd10);
        wait_valid(1'b0, 30, n);
        chk("gate_new", 64'(n), 64'd5);

        // 7 pulses in a 20-cycle rising window
        gate = 8'd19;
        mode = 2'b00;
        wait_valid(1'b0, 30, n);
        chk("gate_5_again", 64'(n), 64'd5);
        for (int k = 0; k < 7; k++) begin
            man[0] = 1'b1;
            step();
            man[0] = 1'b0;
            step();
        end
        wait_valid(1'b0, 30, n);
        chk("g20_rest", 64'(n), 64'd6);
        chk("seven_c0", 64'(count[15:0]), 64'd7);

        // asynchronous reset mid-window, input held high through it
        step();
        step();
        step();
        man[0] = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_count", count, 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_valid(1'b0, 40, n);
        chk("post_rst_len", 64'(n), 64'd21);
        chk("post_rst_c0", 64'(count[15:0]), 64'd0);

        // three pulses, then abort with EN low
        man[0] = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            man[0] = 1'b1;
            step();
            man[0] = 1'b0;
            step();
        end
        wait_valid(1'b0, 30, n);
        chk("three_len", 64'(n), 64'd13);
        chk("three_c0", 64'(count[15:0]), 64'd3);
        for (int k = 0; k < 5; k++) step();
        en = 1'b0;
        step();
        chk("abort_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 30; k++) begin
            man[0] = (k < 20) ? ~man[0] : 1'b0;
            step();
            if (valid) seen = 1'b1;
        end
        chk("abort_novalid", 64'(seen), 64'd0);
        chk("abort_hold", 64'(count[15:0]), 64'd3);
        en = 1'b1;
        step();
        chk("rearm_busy", 64'(busy), 64'd1);
        wait_valid(1'b0, 40, n);
        chk("rearm_len", 64'(n), 64'd20);
        chk("rearm_c0", 64'(count[15:0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Parametrised multi-channel edge counter and frequency meter. Counts qualified edges on CH asynchronous input lines over a programmable gate window derived from a prescaled system clock. At the end of each window it latches all channel counts together and pulses a valid strobe. This is the counting front end that feeds frequency/rate values to downstream display and readout logic, replacing the single-channel divided-clock counter.

## Interface
- CH, 4, number of input channels
- CNT_W, 16, per-channel count width
- GATE_W, 8, gate-length field width
- PRE_W, 16, prescaler field width
- CLK  in  1  system clock; single clock domain, all logic on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- EN  in  1  measurement enable
- PRESCALE  in  PRE_W  tick period minus one, in CLK cycles
- GATE  in  GATE_W  window length minus one, in ticks
- MODE  in  2  edge select, common to all channels: 00 rising, 01 falling, 10 both, 11 treated as rising
- SIG_IN  in  CH  asynchronous input signals
- COUNT  out  CH*CNT_W  latched counts; channel i occupies bits [i*CNT_W +: CNT_W]
- OVF  out  CH  per-channel saturation flag for the latched window
- VALID  out  1  one-cycle strobe; COUNT and OVF updated this cycle
- BUSY  out  1  high while a window is open

## Operation
- Each channel uses a 2-FF synchronizer followed by one history FF. Edges are detected between sync stage 2 and the history FF and qualified by MODE.
- A prescaler counts 0..PRESCALE and emits a tick when it equals PRESCALE, then wraps to 0. PRESCALE=0 gives a tick every cycle.
- A gate counter counts ticks 0..GATE. The window closes on the cycle where the tick fires with gate counter == GATE.
- Window length is (GATE+1)*(PRESCALE+1) CLK cycles.
- PRESCALE, GATE and MODE are sampled into shadow registers at window start. Changes take effect at the next window.
- Per-channel accumulator increments by 1 per qualified edge and saturates at 2^CNT_W-1. A sticky overflow bit is set when an increment is attempted at max.
- On window close, for each channel:
  - COUNT_i ← acc_i + edge_i (saturating).
  - OVF_i ← ovf_i or saturation on this edge.
  - acc_i and ovf_i clear to 0.
  - VALID=1 for that cycle.
  - The next window starts on the following cycle with no gap, so no edge is lost or double-counted.
- EN low:
  - prescaler, gate counter, accumulators and overflow bits are held at 0;
  - BUSY=0 and VALID=0;
  - COUNT and OVF hold their last values.
  - Synchronizers keep running.
- EN rising: the first window starts on the cycle after EN is sampled high, and BUSY rises then. EN falling mid-window aborts the window with no VALID and no COUNT update.
- Reset (RST_N low, any time, including mid-window) clears all state:
  - COUNT=0, OVF=0, VALID=0, BUSY=0;
  - synchronizers, accumulators and counters = 0.
  - After release, the first SIG_IN level sampled is treated as history, so no spurious edge is counted.

## Timing
- SIG_IN transition to accumulator increment: 3 CLK cycles (2 sync + detect).
- An edge detected in the closing cycle counts in the closing window. An edge detected the cycle after counts in the next window.
- VALID period is exactly (GATE+1)*(PRESCALE+1) cycles while EN stays high.
- COUNT/OVF are stable from the VALID cycle until the next VALID or reset.
- SIG_IN pulses shorter than one CLK period may be missed. Inputs must hold each level for at least 2 CLK cycles for guaranteed detection.

## Structure
- Package freq_meter_pkg holds:
  - MODE encodings: MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10;
  - the saturating-increment helper function.
- Sub-module edge_counter_ch holds one channel's synchronizer, edge detect, saturating accumulator and overflow bit. It takes inputs clear, latch and mode, and is instantiated CH times via generate.
- The top level holds the shadow registers, prescaler, gate counter, control FSM (IDLE, RUN) and output registers.

## Test plan
- PRESCALE=0, GATE=9, MODE=rise; ch0 square wave, period 5 cycles (high 3 / low 2) → VALID every 10 cycles, COUNT0=2 in every window after the first. With MODE=both → COUNT0=4.
- CNT_W=4 override, PRESCALE=0, GATE=39; ch1 period 2 cycles (high 1 / low 1) → COUNT1=15, OVF1=1. Next window with ch1 idle → COUNT1=0, OVF1=0.
- Place a single rising edge so it is detected in the closing cycle, then one the cycle after → COUNT=1 in each of two consecutive windows; total equals edges applied.
- Change GATE 9→4 mid-window → current window still 10 cycles, next window 5 cycles.
- Pulse RST_N low mid-window after COUNT=7 was latched → COUNT=0, OVF=0, BUSY=0 immediately. After release, no VALID until a full window elapses, and SIG_IN held high through release counts 0.
- Drop EN mid-window → no VALID, COUNT retains its previous value. Raise EN → BUSY rises the next cycle and VALID arrives exactly one window later.
